// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit for the execute stage.
//
// Owns the HI/LO registers. A mult/multu/div/divu (and madd/maddu when
// MDU_MADD_EN is defined) command computes its result at the issue edge, parks
// it in a pending register, and commits it to HI/LO after a fixed latency while
// busy is held high. mthi/mtlo write immediately. mfhi/mflo are served by the
// combinational md_out port.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu/madd/maddu (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
//
// Build option
//   MDU_MADD_EN  defined: ops 9/10 (madd/maddu) accumulate into {hi,lo};
//                undefined: ops 9/10 behave as no-ops, no accumulate adder.
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous active-high reset
//   md_en   in   1   command valid
//   md_op   in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                    7 mfhi,8 mflo,9 madd,10 maddu, 11-15 none
//   rs      in   32  operand A
//   rt      in   32  operand B
//   busy    out  1   long operation in flight
//   hi      out  32  HI register
//   lo      out  32  LO register
//   md_out  out  32  hi for op 7, lo for op 8, else 0
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_en,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  // state | meaning
  // IDLE  | accepting commands, mthi/mtlo write directly
  // RUN   | result pending in res, cnt counting down to commit
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Datapath, evaluated every cycle from the current operands.
  logic        sgn_op;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, uq, ur, quo, rem;
  logic [63:0] div_res;

  always_comb begin
    sgn_op = (md_op == OP_MULT) || (md_op == OP_DIV) || (md_op == OP_MADD);

    // Low 64 bits of the product of sign/zero-extended operands give the
    // signed or unsigned 32x32 product with one multiplier.
    mul_a = {{32{sgn_op & rs[31]}}, rs};
    mul_b = {{32{sgn_op & rt[31]}}, rt};
    prod  = mul_a * mul_b;

    // Signed division via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    div_zero = (rt == 32'd0);
    a_neg    = sgn_op & rs[31];
    b_neg    = sgn_op & rt[31];
    a_mag    = a_neg ? (~rs + 32'd1) : rs;
    // Divisor forced to 1 when zero so the divider never produces X.
    b_mag    = div_zero ? 32'd1 : (b_neg ? (~rt + 32'd1) : rt);
    uq       = a_mag / b_mag;
    ur       = a_mag % b_mag;
    quo      = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem      = a_neg ? (~ur + 32'd1) : ur;
    // Divide-by-zero parks the current HI/LO so the commit is a no-op;
    // HI/LO cannot change during RUN, so this is the value at completion too.
    div_res  = div_zero ? {hi_q, lo_q} : {rem, quo};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (md_en) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              {res_hi_d, res_lo_d} = prod;
              cnt_d   = MULT_CNT;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              {res_hi_d, res_lo_d} = div_res;
              cnt_d   = DIV_CNT;
              state_d = RUN;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod;
              cnt_d   = MULT_CNT;
              state_d = RUN;
            end
`endif
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    md_out = 32'd0;
    if (md_op == OP_MFHI)      md_out = hi_q;
    else if (md_op == OP_MFLO) md_out = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        md_en = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_en(md_en), .md_op(md_op),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

`ifdef MDU_MADD_EN
  localparam bit HAS_MADD = 1'b1;
`else
  localparam bit HAS_MADD = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;
  bit          m_write = 0;
  int          m_left = 0;   // busy cycles still to go

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_write = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_write) {m_hi, m_lo} = m_pend;
    end else if (md_en) begin
      case (md_op)
        4'd1: begin m_pend = smul(rs, rt); m_write = 1; m_left = MC; end
        4'd2: begin m_pend = umul(rs, rt); m_write = 1; m_left = MC; end
        4'd3: begin
          m_left = DC;
          m_write = (rt != 0);
          if (rt != 0) begin
            int sa, sb;
            sa = $signed(rs);
            sb = $signed(rt);
            if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)
              m_pend = {32'd0, 32'h8000_0000};
            else
              m_pend = {32'(sa % sb), 32'(sa / sb)};
          end
        end
        4'd4: begin
          m_left = DC;
          m_write = (rt != 0);
          if (rt != 0) m_pend = {rs % rt, rs / rt};
        end
        4'd5: m_hi = rs;
        4'd6: m_lo = rs;
        4'd9, 4'd10: if (HAS_MADD) begin
          m_pend = {m_hi, m_lo} + ((md_op == 4'd9) ? smul(rs, rt) : umul(rs, rt));
          m_write = 1; m_left = MC;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] m_md_out(input logic [3:0] op);
    if (op == 4'd7) return m_hi;
    if (op == 4'd8) return m_lo;
    return 32'd0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("md_out", md_out, m_md_out(md_op));
  endtask

  // One cycle: compare outputs of the last edge, then drive next inputs.
  task automatic step(input logic r, input logic e, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_model();
    reset = r; md_en = e; md_op = op; rs = a; rt = b;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // Issue, then count observed busy cycles over a bounded window.
  task automatic issue_count(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, output int nbusy);
    step(1'b0, 1'b1, op, a, b);
    nbusy = 0;
    for (int i = 0; i < DC + 4; i++) begin
      idle();
      if (busy) nbusy++;
    end
  endtask

  int nb;

  initial begin
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    idle();
    idle();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue_count(4'd1, 32'hFFFF_FFFE, 32'd3, nb);
    chk("mult_cycles", nb, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue_count(4'd2, 32'hFFFF_FFFE, 32'd3, nb);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    issue_count(4'd3, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_cycles", nb, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue_count(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    step(1'b0, 1'b1, 4'd5, 32'h11, 32'd0);
    step(1'b0, 1'b1, 4'd6, 32'h22, 32'd0);
    issue_count(4'd4, 32'd7, 32'd0, nb);
    chk("div0_cycles", nb, 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    step(1'b0, 1'b1, 4'd5, 32'h1234, 32'd0);
    step(1'b0, 1'b1, 4'd6, 32'h5678, 32'd0);
    step(1'b0, 1'b0, 4'd7, 32'd0, 32'd0);
    chk("mthi_nobusy", {31'd0, busy}, 32'd0);
    #1 chk("mfhi", md_out, 32'h1234);
    step(1'b0, 1'b0, 4'd8, 32'd0, 32'd0);
    #1 chk("mflo", md_out, 32'h5678);

    step(1'b0, 1'b1, 4'd5, 32'd0, 32'd0);
    step(1'b0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0);
    issue_count(4'd10, 32'd1, 32'd1, nb);
    if (HAS_MADD) begin
      chk("maddu_cycles", nb, 32'd5);
      chk("maddu_hi", hi, 32'd1);
      chk("maddu_lo", lo, 32'd0);
    end else begin
      chk("maddu_off_cycles", nb, 32'd0);
      chk("maddu_off_hi", hi, 32'd0);
      chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
    end

    // div 100/7, mthi during RUN, mult accepted on the first free edge
    step(1'b0, 1'b1, 4'd3, 32'd100, 32'd7);
    idle(); idle();
    step(1'b0, 1'b1, 4'd5, 32'hAAAA, 32'd0);
    for (int i = 0; i < 7; i++) idle();
    step(1'b0, 1'b1, 4'd1, 32'd3, 32'd4);
    chk("div_run_hi", hi, 32'd2);
    chk("div_run_lo", lo, 32'd14);
    idle();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < MC + 1; i++) idle();
    chk("b2b_lo", lo, 32'd12);

    // reset in the middle of a mult
    step(1'b0, 1'b1, 4'd1, 32'd5, 32'd6);
    idle();
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    idle();
    chk("rst_run_busy", {31'd0, busy}, 32'd0);
    chk("rst_run_hi", hi, 32'd0);
    for (int i = 0; i < 8; i++) idle();
    chk("rst_run_lo_late", lo, 32'd0);
    chk("rst_run_busy_late", {31'd0, busy}, 32'd0);

    // randomized traffic, including commands issued while busy
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      logic r, e;
      logic [3:0] op;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 9);
        3: a = 32'(-$urandom_range(1, 100));
        default: ;
      endcase
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 2) != 0);
      op = 4'($urandom_range(0, 15));
      step(r, e, op, a, b);
    end
    for (int i = 0; i < DC + 2; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
